// File: rtl/regfile_write_port_if.sv
// Write-request channel into the register-file write buffer.
// valid/ready: a request {wr_num, wr_data} transfers on a rising edge where wr_valid && wr_ready;
// the master holds wr_num/wr_data stable while wr_valid is high, and wr_ready never depends on wr_valid.
interface regfile_write_port_if #(
   parameter int WIDTH = 16
);
   logic             wr_valid;
   logic             wr_ready;
   logic [2:0]       wr_num;
   logic [WIDTH-1:0] wr_data;

   modport master (output wr_valid, output wr_num, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_num, input wr_data, output wr_ready);
endinterface

// File: rtl/regfile_write_port.sv
// Write side of the 8-entry register file: buffers write requests in a small FIFO
// and commits the head entry into its target register one per cycle.
module regfile_write_port #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   regfile_write_port_if.slave   wr,
   input  logic                  commit_en,
   output logic [WIDTH-1:0]      R0,
   output logic [WIDTH-1:0]      R1,
   output logic [WIDTH-1:0]      R2,
   output logic [WIDTH-1:0]      R3,
   output logic [WIDTH-1:0]      R4,
   output logic [WIDTH-1:0]      R5,
   output logic [WIDTH-1:0]      R6,
   output logic [WIDTH-1:0]      R7,
   output logic [7:0]            decoded_write_num,
   output logic [7:0]            pending,
   output logic [7:0]            commit_count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef logic [PW-1:0] ptr_t;

   logic [2:0]       num_q  [DEPTH];
   logic [2:0]       num_d  [DEPTH];
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   ptr_t             head_q, head_d;
   ptr_t             tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] regs_q [8];
   logic [WIDTH-1:0] regs_d [8];
   logic [7:0]       dec_q, dec_d;
   logic [7:0]       cc_q, cc_d;
   logic             push, pop;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   // Count is zero while in reset, so this alone keeps ready low then.
   assign wr.wr_ready = reset_n && (count_q < CW'(DEPTH));

   assign push = wr.wr_valid && wr.wr_ready;
   assign pop  = commit_en && (count_q != '0);

   always_comb begin
      num_d   = num_q;
      data_d  = data_q;
      regs_d  = regs_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      dec_d   = '0;
      cc_d    = cc_q;
      if (pop) begin
         regs_d[num_q[head_q]] = data_q[head_q];
         dec_d                 = 8'(1) << num_q[head_q];
         cc_d                  = cc_q + 8'd1;
         head_d                = ptr_inc(head_q);
      end
      if (push) begin
         num_d[tail_q]  = wr.wr_num;
         data_d[tail_q] = wr.wr_data;
         tail_d         = ptr_inc(tail_q);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   // A slot is live when its distance from head is below count.
   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'((i + DEPTH - int'(head_q)) % DEPTH) < count_q) begin
            pending = pending | (8'(1) << num_q[i]);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            num_q[i]  <= '0;
            data_q[i] <= '0;
         end
         for (int r = 0; r < 8; r++) begin
            regs_q[r] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         dec_q   <= '0;
         cc_q    <= '0;
      end else begin
         num_q   <= num_d;
         data_q  <= data_d;
         regs_q  <= regs_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         dec_q   <= dec_d;
         cc_q    <= cc_d;
      end
   end

   assign R0 = regs_q[0];
   assign R1 = regs_q[1];
   assign R2 = regs_q[2];
   assign R3 = regs_q[3];
   assign R4 = regs_q[4];
   assign R5 = regs_q[5];
   assign R6 = regs_q[6];
   assign R7 = regs_q[7];

   assign decoded_write_num = dec_q;
   assign commit_count      = cc_q;
endmodule

// File: tb/tb_regfile_write_port.sv
// Bench for regfile_write_port: directed writes, scoreboard of expected commits
// checked by a monitor whenever the DUT reports a commit strobe.
module tb_regfile_write_port;
   localparam int WIDTH = 16;
   localparam int DEPTH = 2;

   logic             clk;
   logic             reset_n;
   logic             commit_en;
   logic [WIDTH-1:0] r_out [8];
   logic [7:0]       decoded_write_num;
   logic [7:0]       pending;
   logic [7:0]       commit_count;

   regfile_write_port_if #(.WIDTH(WIDTH)) wr_if ();

   regfile_write_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .wr                (wr_if),
      .commit_en         (commit_en),
      .R0                (r_out[0]),
      .R1                (r_out[1]),
      .R2                (r_out[2]),
      .R3                (r_out[3]),
      .R4                (r_out[4]),
      .R5                (r_out[5]),
      .R6                (r_out[6]),
      .R7                (r_out[7]),
      .decoded_write_num (decoded_write_num),
      .pending           (pending),
      .commit_count      (commit_count)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboard: {num, data} of each accepted write, in issue order.
   logic [WIDTH+2:0] exp_q [$];
   logic [WIDTH-1:0] reg_m [8];
   logic [7:0]       model_cc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Driver: present a request, wait (bounded) for ready, record it once accepted.
   task automatic send(input logic [2:0] n, input logic [WIDTH-1:0] d);
      int guard;
      guard = 0;
      wr_if.wr_valid = 1'b1;
      wr_if.wr_num   = n;
      wr_if.wr_data  = d;
      while (!wr_if.wr_ready && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (!wr_if.wr_ready) begin
         check("send_timeout", 32'(wr_if.wr_ready), 32'd1);
      end else begin
         exp_q.push_back({n, d});
         @(posedge clk);
         #1;
      end
      wr_if.wr_valid = 1'b0;
   endtask

   task automatic check_all_regs_zero(input string name);
      for (int r = 0; r < 8; r++) begin
         check(name, 32'(r_out[r]), 32'd0);
      end
   endtask

   // Monitor: every commit strobe pops one expected write and checks the register file.
   initial begin
      logic [WIDTH+2:0] e;
      logic [2:0]       en;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            exp_q.delete();
            model_cc = 8'd0;
            for (int r = 0; r < 8; r++) reg_m[r] = '0;
         end else if (decoded_write_num != 8'd0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_commit", 32'(decoded_write_num), 32'd0);
            end else begin
               e  = exp_q.pop_front();
               en = e[WIDTH+2:WIDTH];
               reg_m[en] = e[WIDTH-1:0];
               model_cc  = model_cc + 8'd1;
               check("commit_strobe", 32'(decoded_write_num), 32'(8'(1) << en));
               check("commit_count", 32'(commit_count), 32'(model_cc));
               for (int r = 0; r < 8; r++) begin
                  check("reg_value", 32'(r_out[r]), 32'(reg_m[r]));
               end
            end
         end
      end
   end

   initial begin
      reset_n        = 1'b0;
      commit_en      = 1'b1;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_num   = '0;
      wr_if.wr_data  = '0;
      #2;
      check_all_regs_zero("reset_regs");
      check("reset_dec", 32'(decoded_write_num), 32'd0);
      check("reset_cc", 32'(commit_count), 32'd0);
      check("reset_pending", 32'(pending), 32'd0);
      check("reset_ready", 32'(wr_if.wr_ready), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_reset", 32'(wr_if.wr_ready), 32'd1);

      // Single write: accept at edge 1, commit at edge 2, strobe gone at edge 3.
      send(3'd3, 16'hBEEF);
      check("single_pending", 32'(pending), 32'h08);
      @(posedge clk);
      #1;
      check("single_pending_clr", 32'(pending), 32'h00);
      check("single_r3", 32'(r_out[3]), 32'hBEEF);
      @(posedge clk);
      #1;
      check("single_dec_clr", 32'(decoded_write_num), 32'h00);

      // Fill with drain stalled, refuse a third, then drain.
      commit_en = 1'b0;
      send(3'd1, 16'h0011);
      send(3'd2, 16'h0022);
      check("full_ready", 32'(wr_if.wr_ready), 32'd0);
      check("full_pending", 32'(pending), 32'h06);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_num   = 3'd4;
      wr_if.wr_data  = 16'h0044;
      for (int k = 0; k < 2; k++) begin
         check("full_refuse", 32'(wr_if.wr_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      wr_if.wr_valid = 1'b0;
      check("stalled_r1", 32'(r_out[1]), 32'd0);
      commit_en = 1'b1;
      @(posedge clk);
      #1;
      check("drain1_ready", 32'(wr_if.wr_ready), 32'd1);
      check("drain1_pending", 32'(pending), 32'h04);
      check("drain1_r2_hold", 32'(r_out[2]), 32'd0);
      @(posedge clk);
      #1;
      check("drain2_pending", 32'(pending), 32'h00);
      check("refused_r4", 32'(r_out[4]), 32'd0);

      // Continuous stream: one accept and one commit per cycle.
      for (int i = 0; i < 8; i++) begin
         wr_if.wr_valid = 1'b1;
         wr_if.wr_num   = 3'(i);
         wr_if.wr_data  = 16'(16'h1000 + i * 16'h0101);
         check("stream_ready", 32'(wr_if.wr_ready), 32'd1);
         exp_q.push_back({3'(i), 16'(16'h1000 + i * 16'h0101)});
         @(posedge clk);
         #1;
         check("stream_pending", 32'(pending), 32'(8'(1) << i));
      end
      wr_if.wr_valid = 1'b0;
      @(posedge clk);
      #1;
      check("stream_pending_clr", 32'(pending), 32'h00);

      // Same register twice: later data wins, pending holds until the second commit.
      commit_en = 1'b0;
      send(3'd5, 16'h0001);
      send(3'd5, 16'h0002);
      check("dup_pending", 32'(pending), 32'h20);
      commit_en = 1'b1;
      @(posedge clk);
      #1;
      check("dup_pending_mid", 32'(pending), 32'h20);
      check("dup_r5_first", 32'(r_out[5]), 32'h0001);
      @(posedge clk);
      #1;
      check("dup_pending_clr", 32'(pending), 32'h00);
      check("dup_r5_final", 32'(r_out[5]), 32'h0002);
      @(posedge clk);
      #1;

      // Asynchronous reset with two entries buffered.
      commit_en = 1'b0;
      send(3'd6, 16'hAAAA);
      send(3'd7, 16'hBBBB);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_regs_zero("async_reset_regs");
      check("async_reset_pending", 32'(pending), 32'd0);
      check("async_reset_ready", 32'(wr_if.wr_ready), 32'd0);
      check("async_reset_cc", 32'(commit_count), 32'd0);
      @(negedge clk);
      @(negedge clk);
      #1;
      reset_n   = 1'b1;
      commit_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_reset_r6", 32'(r_out[6]), 32'd0);
      check("post_reset_r7", 32'(r_out[7]), 32'd0);
      check("post_reset_pending", 32'(pending), 32'd0);
      check("post_reset_ready", 32'(wr_if.wr_ready), 32'd1);

      // 256 commits from reset wrap commit_count to zero.
      for (int i = 0; i < 256; i++) begin
         wr_if.wr_valid = 1'b1;
         wr_if.wr_num   = 3'(i % 8);
         wr_if.wr_data  = 16'(i * 3 + 1);
         if (!wr_if.wr_ready) check("wrap_ready", 32'(wr_if.wr_ready), 32'd1);
         exp_q.push_back({3'(i % 8), 16'(i * 3 + 1)});
         @(posedge clk);
         #1;
      end
      wr_if.wr_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("wrap_cc", 32'(commit_count), 32'd0);
      check("wrap_r7", 32'(r_out[7]), 32'(255 * 3 + 1));
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
- Write side of the 8 x 16-bit register file. Its R0..R7 outputs feed the one-hot-select read mux.
- Accepts write requests (binary register number plus data) over a valid/ready handshake and buffers them in a small FIFO.
- Commits one buffered write per cycle into the addressed register.
- Drives a one-hot write strobe and a per-register pending mask, which the datapath uses to stall reads of registers with writes still in flight.

Parameters:
- WIDTH, 16, data width of each register and of wr_data.
- DEPTH, 2, write-buffer depth in entries (legal range 1..4).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- wr_valid  input  1  write request present.
- wr_ready  output  1  buffer can accept a request this cycle.
- wr_num  input  3  binary target register number, 0..7.
- wr_data  input  WIDTH  data to write.
- commit_en  input  1  allows the buffer head to commit this cycle; low stalls the drain.
- R0..R7  output  WIDTH each  register contents, registered.
- decoded_write_num  output  8  one-hot strobe for the register committed at the most recent edge; zero if nothing committed.
- pending  output  8  bit i set while any buffered entry targets register i.
- commit_count  output  8  number of commits, wraps modulo 256.

Behaviour:
- Reset (async, reset_n=0):
  - R0..R7 = 0, FIFO empty (count 0), decoded_write_num = 0, commit_count = 0.
  - pending = 0, wr_ready = 0 while reset is asserted.
  - Reset mid-operation discards all buffered writes. Registers return to 0 immediately, without waiting for a clock edge.
- wr_ready = reset_n && (count < DEPTH). It is combinational from state only and does not depend on wr_valid, and there is no full-buffer bypass.
- Accept: a request is accepted on a rising edge where wr_valid && wr_ready. The {wr_num, wr_data} pair is pushed at the tail.
- Commit: on a rising edge where count > 0 and commit_en = 1:
  - the head entry is popped;
  - R[head.num] <= head.data, and all other registers hold;
  - decoded_write_num <= 1 << head.num;
  - commit_count <= commit_count + 1 (255 -> 0).
- If no commit occurs on an edge, decoded_write_num <= 0.
- Latency: a write accepted at edge N into an empty buffer is committed at edge N+1 if commit_en is high then. It is never visible at edge N.
- Simultaneous accept and commit on the same edge:
  - count is unchanged;
  - the pushed entry lands behind the popped one;
  - order is strictly FIFO.
- Same register written twice in the buffer: both entries commit in order, and the later data wins.
- Full (count = DEPTH): wr_ready = 0 and requests are held off. A commit on that edge frees a slot; wr_ready rises in the next cycle.
- Empty: commit_en has no effect, registers hold, decoded_write_num = 0.
- commit_en low: buffer contents and registers hold; accepts are still allowed while not full.
- pending:
  - Combinational OR over valid entries of (1 << entry.num).
  - It updates after every edge.
  - A bit clears in the cycle after the last entry for that register commits.
- Pointers wrap modulo DEPTH. count is held in a separate counter, so full and empty are unambiguous.
- wr_num is 3 bits, so every value is legal and no error path exists.

Test Plan:
- Reset, then a single write (wr_num=3, wr_data=16'hBEEF, commit_en=1):
  - accept at edge 1;
  - edge 2: R3=16'hBEEF, decoded_write_num=8'b00001000, commit_count=1;
  - edge 3: decoded_write_num=0.
  - pending=8'b00001000 only between edges 1 and 2.
- commit_en=0, DEPTH=2, writes (1, 16'h0011) then (2, 16'h0022):
  - both are accepted, then wr_ready=0 and a third request is refused;
  - pending=8'b00000110.
  - Raise commit_en: R1 updates, then R2 one cycle later, and wr_ready returns the cycle after the first commit.
- Continuous stream with wr_valid=1 every cycle and commit_en=1: one accept and one commit per cycle, count constant at 1, registers written in issue order.
- Two buffered writes to R5 (16'h0001 then 16'h0002): R5 ends at 16'h0002, decoded_write_num pulses 8'b00100000 twice, and pending[5] clears only after the second commit.
- Assert reset_n=0 mid-cycle with 2 entries buffered: registers, pending and count are 0 at once, before the next edge; no commit follows after release.
- 256 commits from reset: commit_count returns to 0.
